usb_packet_receiver: RTL
========================

USB_PACKET_RECEIVER -- requirements
Module: usb_packet_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clk cycles per USB bit time (even, >=4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter MAX_BYTES, default 64, maximum data bytes per packet after SYNC.
REQ-004 SHALL have parameter STUFF_EN, default 1; 1 = bit-unstuffing enabled, 0 = disabled.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- n_rst  in  1  synchronous, active-high reset; name is kept, polarity is high.
- d_plus  in  1  asynchronous D+ line.
- d_minus  in  1  asynchronous D- line.
- r_enable  in  1  FIFO read strobe.
- r_data  out  8  FIFO head byte, first-word-fall-through.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- rcving  out  1  packet in progress.
- r_error  out  1  sticky packet error.
- pkt_done  out  1  one-cycle pulse on a good EOP.
- pkt_len  out  $clog2(MAX_BYTES+1)  byte count of the last good packet.

Function
REQ-006 SHALL pass each line through a 2-flop synchronizer; reset values are d_plus 1, d_minus 0.
REQ-007 SHALL detect an edge whenever synced d_plus differs from its previous-cycle value.
REQ-008 SHALL run a phase counter 0..CLKS_PER_BIT-1 that wraps and clears to 0 on every edge.
REQ-009 SHALL sample the synced lines when phase == CLKS_PER_BIT/2-1; this is the bit strobe.
REQ-010 SHALL NRZI-decode: bit = 1 if the sampled d_plus equals the previous sample, else 0; the previous sample is preset to 1 on packet start.
REQ-011 SHALL assemble bits LSB-first into an 8-bit shift register.
REQ-012 SHALL unstuff when STUFF_EN=1: after six consecutive decoded 1s, the next bit is discarded; if that bit is 1, it is a stuff error.
REQ-013 SHALL implement FSM states IDLE, SYNC, RECV, EOP, ERR.
REQ-014 IDLE -> SYNC on the first synced d_plus falling edge (J->K); the phase counter clears at that point.
REQ-015 SYNC: after 8 bits, the byte must equal 8'h80; match -> RECV, mismatch -> ERR.
REQ-016 RECV: each 8th data bit writes the byte to the FIFO in the cycle after the strobe and increments the byte count.
REQ-017 RECV: SE0 (both synced lines 0) sampled with 0 pending bits -> EOP; with 1-7 pending bits -> ERR.
REQ-018 EOP: the next strobe must sample SE0 again, then J (d_plus=1, d_minus=0) -> IDLE with pkt_done=1 and pkt_len loaded; any other sample -> ERR.
REQ-019 ERR: set r_error; stay in ERR until a J sample, then go to IDLE; no FIFO writes; no pkt_done.
REQ-020 SHALL treat these as errors (-> ERR): stuff error, SYNC mismatch, misaligned EOP, a byte write while full with no same-cycle read (byte dropped), or byte count exceeding MAX_BYTES.
REQ-021 Bytes already written from an errored packet SHALL remain in the FIFO.
REQ-022 r_error SHALL hold until the next IDLE->SYNC transition, where it clears.
REQ-023 rcving SHALL be 1 in SYNC, RECV, EOP and ERR, and 0 in IDLE.
REQ-024 FIFO: a read while empty is ignored; a write while full is accepted only with a same-cycle read.
REQ-025 FIFO: a simultaneous read and write when not empty leaves count unchanged.
REQ-026 FIFO: pointers wrap modulo FIFO_DEPTH.
REQ-027 FIFO: empty = (count==0), full = (count==FIFO_DEPTH); r_data updates the cycle after a read or a write-into-empty.
REQ-028 pkt_len SHALL hold its value until the next good EOP.

Reset
REQ-029 SHALL, with n_rst high at a clk edge, set the FSM to IDLE, clear the phase and bit counters, and clear the FIFO pointers and count.
REQ-030 SHALL drive reset outputs: r_data=0, empty=1, full=0, count=0, rcving=0, r_error=0, pkt_done=0, pkt_len=0.
REQ-031 Reset mid-packet SHALL abort the packet and flush the FIFO; reception resumes only on a new J->K after reset release.

Verification
REQ-032 Good packet, SYNC + 8'hA5, 8'h3C + EOP -> pkt_done one pulse, pkt_len=2, count=2, reads return A5 then 3C, r_error=0.
REQ-033 Data byte 8'hFF with STUFF_EN=1 and a stuffed 0 -> byte FF stored; stuffed bit forced to 1 -> r_error=1, no pkt_done.
REQ-034 SYNC byte 8'h81 -> r_error=1, count=0; r_error clears on the next packet start.
REQ-035 SE0 after 4 data bits -> r_error=1, rcving stays 1 until J is sampled.
REQ-036 FIFO_DEPTH=4, 5-byte packet with no reads -> full=1 after byte 4, byte 5 dropped, r_error=1; the same case with a read on byte 5's write cycle -> no error, count=4.
REQ-037 n_rst asserted mid-RECV with count=3 -> next cycle count=0, empty=1, rcving=0; line-bit skew of ±1 clk per edge is tolerated at CLKS_PER_BIT=8.

Source files
------------

// File: rtl/usb_packet_receiver.sv
// rtl/usb_packet_receiver.sv - USB full-speed style packet receiver: sync, NRZI decode, unstuff, byte FIFO
module usb_packet_receiver #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int MAX_BYTES    = 64,
    parameter int STUFF_EN     = 1
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              d_plus,
    input  logic                              d_minus,
    input  logic                              r_enable,
    output logic [7:0]                        r_data,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              rcving,
    output logic                              r_error,
    output logic                              pkt_done,
    output logic [$clog2(MAX_BYTES+1)-1:0]    pkt_len
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int LW = $clog2(MAX_BYTES+1);
    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SYNC, RECV, EOP, ERR} state_t;

    logic          dp_meta_q, dp_sync_q, dm_meta_q, dm_sync_q, dp_prev_q;
    logic [PW-1:0] phase_q, phase_d;
    state_t        state_q, state_d;
    logic          prev_smp_q, prev_smp_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d, ones_q, ones_d;
    logic [LW-1:0] byte_cnt_q, byte_cnt_d, pkt_len_q, pkt_len_d;
    logic          wr_pend_q, wr_pend_d, eop_se0_q, eop_se0_d;
    logic          r_error_q, r_error_d, pkt_done_q, pkt_done_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic edge_det, strobe, se0, j_state, nrz_bit, stuff_slot;
    logic fifo_full, fifo_rd, fifo_wr;

    assign edge_det   = dp_sync_q ^ dp_prev_q;
    assign strobe     = (phase_q == PW'(CLKS_PER_BIT/2 - 1));
    assign se0        = !dp_sync_q && !dm_sync_q;
    assign j_state    = dp_sync_q && !dm_sync_q;
    assign nrz_bit    = (dp_sync_q == prev_smp_q);
    assign stuff_slot = (STUFF_EN != 0) && (ones_q == 3'd6);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_rd    = r_enable && (count_q != '0);
    // A full FIFO still takes the byte when the head is popped in the same cycle.
    assign fifo_wr    = wr_pend_q && (state_q == RECV) && (!fifo_full || fifo_rd);

    always_comb begin
        phase_d = edge_det ? '0 : (phase_q == PW'(CLKS_PER_BIT-1)) ? '0 : phase_q + PW'(1);
    end

    always_comb begin
        state_d    = state_q;
        prev_smp_d = prev_smp_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        ones_d     = ones_q;
        byte_cnt_d = byte_cnt_q;
        wr_pend_d  = 1'b0;
        eop_se0_d  = eop_se0_q;
        r_error_d  = r_error_q;
        pkt_done_d = 1'b0;
        pkt_len_d  = pkt_len_q;
        case (state_q)
            IDLE: begin
                if (edge_det && !dp_sync_q) begin
                    state_d    = SYNC;
                    prev_smp_d = 1'b1;
                    bit_cnt_d  = '0;
                    ones_d     = '0;
                    byte_cnt_d = '0;
                    eop_se0_d  = 1'b0;
                    r_error_d  = 1'b0;
                end
            end
            SYNC, RECV: begin
                if (state_q == RECV && wr_pend_q && fifo_full && !fifo_rd) begin
                    state_d = ERR;
                end else if (strobe) begin
                    if (state_q == RECV && se0) begin
                        state_d = (bit_cnt_q == 3'd0) ? EOP : ERR;
                    end else begin
                        prev_smp_d = dp_sync_q;
                        if (stuff_slot) begin
                            ones_d = '0;
                            if (nrz_bit) state_d = ERR;
                        end else begin
                            shift_d   = {nrz_bit, shift_q[7:1]};
                            ones_d    = nrz_bit ? ones_q + 3'd1 : 3'd0;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == SYNC) begin
                                    state_d = (shift_d == 8'h80) ? RECV : ERR;
                                end else if (byte_cnt_q == LW'(MAX_BYTES)) begin
                                    state_d = ERR;
                                end else begin
                                    byte_cnt_d = byte_cnt_q + LW'(1);
                                    wr_pend_d  = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            EOP: begin
                if (strobe) begin
                    if (!eop_se0_q) begin
                        if (se0) eop_se0_d = 1'b1;
                        else     state_d   = ERR;
                    end else if (j_state) begin
                        state_d    = IDLE;
                        pkt_done_d = 1'b1;
                        pkt_len_d  = byte_cnt_q;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                if (strobe && j_state) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ERR) r_error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            dp_meta_q  <= 1'b1;
            dp_sync_q  <= 1'b1;
            dm_meta_q  <= 1'b0;
            dm_sync_q  <= 1'b0;
            dp_prev_q  <= 1'b1;
            phase_q    <= '0;
            state_q    <= IDLE;
            prev_smp_q <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            ones_q     <= '0;
            byte_cnt_q <= '0;
            wr_pend_q  <= 1'b0;
            eop_se0_q  <= 1'b0;
            r_error_q  <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_len_q  <= '0;
        end else begin
            dp_meta_q  <= d_plus;
            dp_sync_q  <= dp_meta_q;
            dm_meta_q  <= d_minus;
            dm_sync_q  <= dm_meta_q;
            dp_prev_q  <= dp_sync_q;
            phase_q    <= phase_d;
            state_q    <= state_d;
            prev_smp_q <= prev_smp_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            byte_cnt_q <= byte_cnt_d;
            wr_pend_q  <= wr_pend_d;
            eop_se0_q  <= eop_se0_d;
            r_error_q  <= r_error_d;
            pkt_done_q <= pkt_done_d;
            pkt_len_q  <= pkt_len_d;
        end
    end

    // Storage is cleared on reset so the fall-through head reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (fifo_wr) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (fifo_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({fifo_wr, fifo_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign r_data   = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = fifo_full;
    assign count    = count_q;
    assign rcving   = (state_q != IDLE);
    assign r_error  = r_error_q;
    assign pkt_done = pkt_done_q;
    assign pkt_len  = pkt_len_q;
endmodule
